input_module: RTL

- Router input port and receive end of the inter-router link; the output modules are the transmit end.
- Accepts 64-bit flits from a neighbour link with a valid/ready handshake and buffers them in a 32-slot FIFO.
- Computes the XY route from each head flit and forwards the packet wormhole-style: it writes into the VC of the target output module that is reserved for this port.
- Honours per-output full backpressure.

---
 rtl/noc_pkg.sv | 34 +++
 rtl/vc_buffer.sv | 51 +++++
 rtl/xy_route.sv | 26 ++
 rtl/input_module.sv | 112 +++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: port codes, flit type codes and flit field positions.
package noc_pkg;

  localparam int DATA_W_DEFAULT = 64;

  typedef enum logic [2:0] {
    PORT_N       = 3'b000,
    PORT_S       = 3'b001,
    PORT_E       = 3'b010,
    PORT_W       = 3'b011,
    PORT_L       = 3'b100,
    PORT_INVALID = 3'b111
  } port_e;

  typedef enum logic [1:0] {
    FLIT_HEAD   = 2'b00,
    FLIT_BODY   = 2'b01,
    FLIT_TAIL   = 2'b10,
    FLIT_SINGLE = 2'b11
  } flit_type_e;

  localparam int TYPE_LSB   = 62;
  localparam int DEST_X_LSB = 58;
  localparam int DEST_Y_LSB = 54;

  function automatic logic opens_packet(flit_type_e t);
    return (t == FLIT_HEAD) || (t == FLIT_SINGLE);
  endfunction

  function automatic logic closes_packet(flit_type_e t);
    return (t == FLIT_TAIL) || (t == FLIT_SINGLE);
  endfunction

endpackage

// File: rtl/vc_buffer.sv
// First-word fall-through FIFO; push is ignored when full, pop is ignored when empty.
module vc_buffer #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count;
  logic              do_push, do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // NOTE: storage is deliberately not reset; count and pointers alone define which slots are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/xy_route.sv
// Dimension-ordered XY routing: resolve X first, then Y, else deliver locally.
module xy_route
  import noc_pkg::*;
#(
  parameter int COORD_W = 4,
  parameter int X_ID    = 0,
  parameter int Y_ID    = 0
) (
  input  logic [COORD_W-1:0] dest_x,
  input  logic [COORD_W-1:0] dest_y,
  output port_e              port
);

  localparam logic [COORD_W-1:0] X_C = COORD_W'(X_ID);
  localparam logic [COORD_W-1:0] Y_C = COORD_W'(Y_ID);

  always_comb begin
    // NOTE: default assignment first so every path drives port and no latch is inferred.
    port = PORT_L;
    if (dest_x > X_C)      port = PORT_E;
    else if (dest_x < X_C) port = PORT_W;
    else if (dest_y > Y_C) port = PORT_N;
    else if (dest_y < Y_C) port = PORT_S;
  end

endmodule

// File: rtl/input_module.sv
// Router input port: link FIFO, XY route decode on head flits, wormhole forwarding.
// Define INPUT_STATS_EN to add saturating forwarded-flit and drop counters.
module input_module
  import noc_pkg::*;
#(
  parameter int         DATA_W  = DATA_W_DEFAULT,
  parameter int         DEPTH   = 32,
  parameter int         COORD_W = 4,
  parameter int         X_ID    = 0,
  parameter int         Y_ID    = 0,
  parameter logic [2:0] PORT_ID = 3'b000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] link_data_in,
  input  logic              link_valid,
  output logic              link_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_write_en,
  output logic [2:0]        out_port_select,
  output logic [2:0]        out_vc_select,
  input  logic [4:0]        out_full_vec,
  output logic              proto_error
`ifdef INPUT_STATS_EN
  ,
  output logic [15:0]       stat_flits,
  output logic [7:0]        stat_drops
`endif
);

  typedef enum logic {IDLE, FORWARD} state_e;

  state_e            state;
  logic [DATA_W-1:0] head;
  logic              full, empty, target_full, fwd_go, drop;
  flit_type_e        head_type;
  port_e             route;

  assign link_ready = !reset && !full;

  vc_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (link_valid && link_ready),
    .pop   (fwd_go || drop),
    .din   (link_data_in),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  assign head_type = flit_type_e'(head[TYPE_LSB +: 2]);

  xy_route #(.COORD_W(COORD_W), .X_ID(X_ID), .Y_ID(Y_ID)) u_route (
    .dest_x (head[DEST_X_LSB +: COORD_W]),
    .dest_y (head[DEST_Y_LSB +: COORD_W]),
    .port   (route)
  );

  // Codes above L never reach FORWARD; treating them as full keeps the index in range.
  always_comb begin
    target_full = 1'b1;
    if (out_port_select <= PORT_L) target_full = out_full_vec[out_port_select];
  end

  assign fwd_go = !reset && (state == FORWARD) && !empty && !target_full;
  assign drop   = !reset && (state == IDLE) && !empty && !opens_packet(head_type);

  assign out_write_en  = fwd_go;
  assign out_data      = fwd_go ? head : '0;
  assign out_vc_select = PORT_ID;
  assign proto_error   = drop;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      out_port_select <= PORT_INVALID;
    end else begin
      case (state)
        IDLE: begin
          if (!empty && opens_packet(head_type)) begin
            out_port_select <= route;
            state           <= FORWARD;
          end
        end
        FORWARD: begin
          if (fwd_go && closes_packet(head_type)) begin
            out_port_select <= PORT_INVALID;
            state           <= IDLE;
          end
        end
        default: begin
          out_port_select <= PORT_INVALID;
          state           <= IDLE;
        end
      endcase
    end
  end

`ifdef INPUT_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_flits <= '0;
      stat_drops <= '0;
    end else begin
      if (fwd_go && (stat_flits != '1)) stat_flits <= stat_flits + 16'd1;
      if (drop && (stat_drops != '1))   stat_drops <= stat_drops + 8'd1;
    end
  end
`endif

endmodule
